// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - start/done handshake bundle between the EX-stage control FSM and multicycle_alu
//
// Purpose: groups the request, operand and result signals of the multicycle ALU.
// Ports (signals):
//   iStart          request, accepted only when oBusy is low
//   iControlSignal  5-bit ALU control code
//   iA, iB          operands (iB low bits carry the shift amount)
//   oBusy           high while a shift iterates
//   oDone           one-cycle pulse, oResult/oInvalid updated
//   oResult         result register, held until next oDone
//   oZero           oResult == 0
//   oInvalid        last completed code was not recognised
// Modports: master drives requests (control FSM / bench), slave is the ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic [4:0]       iControlSignal;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oResult;
  logic             oZero;
  logic             oInvalid;

  modport master (
    output iStart, iControlSignal, iA, iB,
    input  oBusy, oDone, oResult, oZero, oInvalid
  );

  modport slave (
    input  iStart, iControlSignal, iA, iB,
    output oBusy, oDone, oResult, oZero, oInvalid
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - sequential ALU with single-cycle logic/arith ops and bit-serial shifts
//
// Purpose: executes a 5-bit ALU control code on two operands. Logic, arithmetic,
// compare and LUI complete one cycle after accept; shifts iterate one bit per cycle
// so no barrel shifter sits on the critical path.
// Ports:
//   iCLK  clock, rising edge
//   iRST  synchronous active-low reset
//   bus   multicycle_alu_if.slave (iStart, iControlSignal, iA, iB,
//         oBusy, oDone, oResult, oZero, oInvalid)
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic            iCLK,
  input  logic            iRST,
  multicycle_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  // ALU control codes shared with the control decoder
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_LUI  = 5'd10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_kind_t;

  state_t      state;
  shift_kind_t shift_kind;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             invalid;

  logic [WIDTH-1:0] comb_result;
  logic             comb_invalid;
  logic             comb_is_shift;
  shift_kind_t      comb_kind;
  logic [WIDTH-1:0] shift_next;
  logic [SHW-1:0]   shamt;

  assign shamt = bus.iB[SHW-1:0];

  // Single-cycle datapath. Shift codes pass iA through so that a zero shift
  // amount completes on the single-cycle path with oResult = iA.
  always_comb begin
    comb_result   = '0;
    comb_invalid  = 1'b0;
    comb_is_shift = 1'b0;
    comb_kind     = SH_LL;
    case (bus.iControlSignal)
      OP_ADD:  comb_result = bus.iA + bus.iB;
      OP_SUB:  comb_result = bus.iA - bus.iB;
      OP_AND:  comb_result = bus.iA & bus.iB;
      OP_OR:   comb_result = bus.iA | bus.iB;
      OP_XOR:  comb_result = bus.iA ^ bus.iB;
      OP_SLT:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(bus.iA) < $signed(bus.iB))};
      OP_SLTU: comb_result = {{(WIDTH-1){1'b0}}, (bus.iA < bus.iB)};
      OP_LUI:  comb_result = bus.iB;
      OP_SLL: begin
        comb_result   = bus.iA;
        comb_is_shift = 1'b1;
        comb_kind     = SH_LL;
      end
      OP_SRL: begin
        comb_result   = bus.iA;
        comb_is_shift = 1'b1;
        comb_kind     = SH_RL;
      end
      OP_SRA: begin
        comb_result   = bus.iA;
        comb_is_shift = 1'b1;
        comb_kind     = SH_RA;
      end
      default: comb_invalid = 1'b1;
    endcase
  end

  // One-bit step of the latched shift register
  always_comb begin
    shift_next = shreg;
    case (shift_kind)
      SH_LL:   shift_next = {shreg[WIDTH-2:0], 1'b0};
      SH_RL:   shift_next = {1'b0, shreg[WIDTH-1:1]};
      SH_RA:   shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shift_next = shreg;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state      <= IDLE;
      shift_kind <= SH_LL;
      shreg      <= '0;
      count      <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            if (comb_is_shift && (shamt != '0)) begin
              shreg      <= bus.iA;
              count      <= shamt;
              shift_kind <= comb_kind;
              busy       <= 1'b1;
              state      <= SHIFT;
            end else begin
              result  <= comb_result;
              invalid <= comb_invalid;
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // iStart is not looked at here: requests during a shift are dropped
          shreg <= shift_next;
          count <= count - SHW'(1);
          if (count == SHW'(1)) begin
            result  <= shift_next;
            invalid <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oBusy    = busy;
  assign bus.oDone    = done;
  assign bus.oResult  = result;
  assign bus.oZero    = (result == '0);
  assign bus.oInvalid = invalid;

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Sequential ALU that consumes the 5-bit ALU control code produced by the ALU control decoder and executes it on two operands. Logic, arithmetic, compare and LUI codes complete in one cycle. Shift codes iterate one bit per cycle, which keeps the barrel shifter off the critical path. It sits in the EX stage of the multicycle core. The control FSM drives it with a start/done handshake and uses oZero and oResult for branches and write-back.

## Interface
- WIDTH, 32, operand/result width; shift amount is iB[$clog2(WIDTH)-1:0]
- iCLK  in  1  clock, all state updates on rising edge
- iRST  in  1  reset, synchronous, active-low
- iStart  in  1  request; accepted only when oBusy=0
- iControlSignal  in  5  ALU control code (OPADD, OPSUB, OPAND, OPOR, OPXOR, OPSLT, OPSLTU, OPSLL, OPSRL, OPSRA, OPLUI; values from the shared parameters file)
- iA  in  WIDTH  operand A (rs1)
- iB  in  WIDTH  operand B (rs2 or immediate)
- oBusy  out  1  high while a shift iterates
- oDone  out  1  one-cycle pulse: oResult valid and updated
- oResult  out  WIDTH  result, held until next oDone
- oZero  out  1  oResult == 0, combinational from the oResult register
- oInvalid  out  1  registered with oDone: code was not a recognised operation

## Operation
- FSM states: IDLE, SHIFT. Reset to IDLE.
- IDLE + iStart: sample iControlSignal, iA and iB.
  - Single-cycle code: write oResult, pulse oDone next cycle, stay in IDLE.
  - Shift code with shamt=0: oResult=iA, oDone next cycle, stay in IDLE.
  - Shift code with shamt=k>0: latch iA into the shift register and k into the counter, then go to SHIFT.
- Single-cycle results:
  - ADD: A+B mod 2^WIDTH. SUB: A-B mod 2^WIDTH. Carry and overflow are discarded.
  - AND/OR/XOR: bitwise.
  - SLT: 1 if signed A<B, else 0. SLTU: same, unsigned.
  - LUI: result = B, because the immediate arrives pre-shifted.
- SHIFT: each cycle, shift the register by 1 and decrement the counter.
  - SLL fills with 0. SRL fills with 0. SRA replicates the MSB.
  - When the counter goes 1→0, write the register to oResult, pulse oDone and return to IDLE.
- Unrecognised code: oResult=0, oInvalid=1, single-cycle timing.
- iStart while oBusy=1 is ignored: no queueing, no effect on the in-flight operation.
- Operand changes during SHIFT have no effect, because they were latched at accept.

## Timing
- Accept in cycle N.
  - Non-shift (or shamt=0): oDone=1 in N+1.
  - Shift by k>0: oBusy=1 in N+1..N+k, oDone=1 in N+k+1 with oBusy=0.
- oBusy is low in the oDone cycle, so a new iStart in that cycle is accepted. Back-to-back single-cycle ops run at one result per cycle.
- oInvalid updates only in oDone cycles and holds otherwise.
- Reset values: oBusy=0, oDone=0, oResult=0, oZero=1, oInvalid=0, state IDLE.
- Reset asserted mid-shift (iRST=0 at any edge):
  - Abort the operation and force the reset values.
  - No oDone for the aborted operation.
  - iStart is ignored while iRST=0.
- Simultaneous reset and iStart: reset wins.

## Test plan
- Reset, then OPADD with A=0xFFFFFFFF, B=0x00000001 → oDone next cycle, oResult=0x00000000, oZero=1, oInvalid=0.
- OPSLT with A=0xFFFFFFFE, B=0x00000001 → oResult=1. OPSLTU with the same operands → oResult=0. Issue both back-to-back and check oDone on consecutive cycles.
- OPSRA with A=0x80000000, B=0x0000001F → oBusy high for 31 cycles, oDone at N+32, oResult=0xFFFFFFFF. Pulse iStart mid-shift and check it is ignored.
- OPSLL with A=0x00000001, B=0x00000020 (shamt=0) → oDone at N+1, oResult=0x00000001. OPSRL with A=0xF0000000, shamt=4 → oDone at N+5, oResult=0x0F000000.
- Unrecognised code 5'b11111 with A=5, B=3 → oDone at N+1, oResult=0, oInvalid=1. Follow with OPSUB 5-5 → oInvalid=0, oZero=1.
- OPSLL with shamt=10, then drive iRST=0 at N+4 → at the next edge all outputs take reset values, no oDone appears, and a fresh OPOR 0x0F|0xF0 after reset gives 0xFF.
